// File: rtl/h264_tx_pkg.sv
// Shared types and width defaults for the H.264 forward transform path.
package h264_tx_pkg;

    localparam int RES_WIDTH_DEF   = 9;
    localparam int COEFF_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        COL  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic signed [COEFF_WIDTH_DEF-1:0] coeff_t;

endpackage

// File: rtl/fwd_butterfly4.sv
// Combinational 4-point H.264 forward core-transform butterfly.
// Inputs are sign-extended to the output width before any arithmetic.
module fwd_butterfly4 #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16
) (
    input  logic [0:3][IN_W-1:0]  a,
    output logic [0:3][OUT_W-1:0] y
);

    logic signed [OUT_W-1:0] e [0:3];
    logic signed [OUT_W-1:0] s0, s1, d0, d1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ext
            assign e[gi] = OUT_W'($signed(a[gi]));
        end
    endgenerate

    assign s0 = e[0] + e[3];
    assign s1 = e[1] + e[2];
    assign d0 = e[0] - e[3];
    assign d1 = e[1] - e[2];

    assign y[0] = s0 + s1;
    assign y[1] = (d0 <<< 1) + d1;
    assign y[2] = s0 - s1;
    assign y[3] = d0 - (d1 <<< 1);

endmodule

// File: rtl/fwd_tx4x4_lc.sv
// Low-cost 4x4 forward integer transform: one shared butterfly, row pass then column pass.
// Optional feature macro: FWD_TX_ZERO_FLAG_EN adds the registered all_zero output.
module fwd_tx4x4_lc
    import h264_tx_pkg::*;
#(
    parameter int MB_SIZE     = 4,
    parameter int RES_WIDTH   = RES_WIDTH_DEF,
    parameter int COEFF_WIDTH = COEFF_WIDTH_DEF
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [0:MB_SIZE-1][0:MB_SIZE-1][RES_WIDTH-1:0]      residual,
    input  logic                                                src_valid,
    output logic                                                src_ready,
    output logic                                                dst_valid,
    input  logic                                                dst_ready,
    output logic signed [0:MB_SIZE-1][0:MB_SIZE-1][COEFF_WIDTH-1:0] coeff
`ifdef FWD_TX_ZERO_FLAG_EN
    ,
    output logic                                                all_zero
`endif
);

    localparam int N   = MB_SIZE;
    localparam int T_W = RES_WIDTH + 3;

    state_t     state_reg, state_next;
    logic [1:0] idx_reg, idx_next;
    logic       accept;

    logic [0:N-1][0:N-1][RES_WIDTH-1:0]   x_reg;
    logic [0:N-1][0:N-1][T_W-1:0]         t_reg;
    logic [0:N-1][0:N-1][COEFF_WIDTH-1:0] coeff_reg;

    logic [0:N-1][T_W-1:0]         bf_in;
    logic [0:N-1][COEFF_WIDTH-1:0] bf_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        src_ready  = 1'b0;
        dst_valid  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    accept     = 1'b1;
                    idx_next   = 2'd0;
                    state_next = ROW;
                end
            end
            ROW: begin
                // idx wraps 3 -> 0 on its own, ready for the column pass
                idx_next = idx_reg + 2'd1;
                if (idx_reg == 2'd3) state_next = COL;
            end
            COL: begin
                idx_next = idx_reg + 2'd1;
                if (idx_reg == 2'd3) state_next = DONE;
            end
            DONE: begin
                dst_valid = 1'b1;
                if (dst_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Row pass feeds sign-extended X rows; column pass feeds T columns.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mux
            assign bf_in[gi] = (state_reg == ROW)
                ? {{3{x_reg[idx_reg][gi][RES_WIDTH-1]}}, x_reg[idx_reg][gi]}
                : t_reg[gi][idx_reg];
        end
    endgenerate

    fwd_butterfly4 #(
        .IN_W  (T_W),
        .OUT_W (COEFF_WIDTH)
    ) u_bfly (
        .a (bf_in),
        .y (bf_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg     <= '0;
            t_reg     <= '0;
            coeff_reg <= '0;
        end else begin
            if (accept) x_reg <= residual;
            if (state_reg == ROW) begin
                for (int k = 0; k < N; k++) t_reg[idx_reg][k] <= bf_out[k][T_W-1:0];
            end
            if (state_reg == COL) begin
                for (int k = 0; k < N; k++) coeff_reg[k][idx_reg] <= bf_out[k];
            end
        end
    end

    assign coeff = coeff_reg;

`ifdef FWD_TX_ZERO_FLAG_EN
    logic prev_zero;

    // Columns 0..2 are already registered when the last column is computed.
    always_comb begin
        prev_zero = 1'b1;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N - 1; c++) begin
                if (coeff_reg[r][c] != '0) prev_zero = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            all_zero <= 1'b0;
        end else if (state_reg == COL && idx_reg == 2'd3) begin
            all_zero <= prev_zero && (bf_out == '0);
        end
    end
`endif

endmodule
